// File: rtl/spi_pkg.sv
// Constants shared between the sclk-domain SPI front-end and the clk-domain
// command decoder / matrix loader.
package spi_pkg;

  localparam int SPI_W = 8;
  localparam logic [SPI_W-1:0] IDLE_TX_DEFAULT = 8'hA5;

  localparam logic [SPI_W-1:0] CMD_LOAD_A = 8'h10;
  localparam logic [SPI_W-1:0] CMD_LOAD_B = 8'h20;
  localparam logic [SPI_W-1:0] CMD_START  = 8'h30;
  localparam logic [SPI_W-1:0] CMD_READ   = 8'h40;

  typedef enum logic [SPI_W-1:0] {
    OP_LOAD_A = CMD_LOAD_A,
    OP_LOAD_B = CMD_LOAD_B,
    OP_START  = CMD_START,
    OP_READ   = CMD_READ
  } spi_cmd_e;

  function automatic logic is_known_cmd(input logic [SPI_W-1:0] b);
    return (b == CMD_LOAD_A) || (b == CMD_LOAD_B) ||
           (b == CMD_START)  || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_slave_frontend.sv
// SPI mode 0 slave front-end (MSB first): byte deserialiser with toggle handshake
// for a clk-domain consumer, plus reply serialiser on MISO.
module spi_slave_frontend
  import spi_pkg::*;
#(
  parameter int                DATA_W  = SPI_W,
  parameter int                COUNT_W = 6,
  parameter logic [DATA_W-1:0] IDLE_TX = IDLE_TX_DEFAULT
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  input  logic [DATA_W-1:0]  tx_byte,
  output logic [DATA_W-1:0]  rx_byte,
  output logic               rx_toggle,
  output logic               rx_first,
  output logic [DATA_W-1:0]  cmd_byte,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              new_frame;
  logic              miso_q;
  logic [DATA_W-1:0] rx_next;
  logic              byte_done;
  logic              frame_clr_n;

  // Deasserted chip select clears the frame state asynchronously; the consumer-
  // facing outputs are only cleared by rst_n so they survive between frames.
  assign frame_clr_n = rst_n & ~cs_n;
  assign rx_next     = {rx_shift[DATA_W-2:0], mosi};
  assign byte_done   = (bit_cnt == LAST_BIT);
  assign miso        = miso_q;

  always_ff @(posedge sclk or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= IDLE_TX;
      new_frame <= 1'b1;
    end else begin
      rx_shift <= rx_next;
      bit_cnt  <= bit_cnt + 1'b1;
      if (byte_done) begin
        tx_shift  <= tx_byte;
        new_frame <= 1'b0;
      end else begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge sclk or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      miso_q <= IDLE_TX[DATA_W-1];
    end else begin
      miso_q <= tx_shift[DATA_W-1];
    end
  end

  // rx_byte/rx_first move together with rx_toggle and then hold for a whole byte
  // time, which is what the consumer's toggle synchroniser relies on.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte    <= '0;
      rx_toggle  <= 1'b0;
      rx_first   <= 1'b0;
      cmd_byte   <= '0;
      byte_count <= '0;
    end else if (!cs_n && byte_done) begin
      rx_byte   <= rx_next;
      rx_toggle <= ~rx_toggle;
      rx_first  <= new_frame;
      if (new_frame) begin
        cmd_byte   <= rx_next;
        byte_count <= COUNT_W'(1);
      end else if (byte_count != '1) begin
        byte_count <= byte_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Scoreboard bench for spi_slave_frontend: a bench-side SPI master drives frames,
// expected receive state and MISO bytes are queued per byte and popped on completion.
module tb_spi_slave_frontend;

  localparam logic [7:0] IDLE = 8'hA5;

  logic       sclk, rst_n, cs_n, mosi, miso;
  logic [7:0] tx_byte, rx_byte, cmd_byte;
  logic       rx_toggle, rx_first;
  logic [5:0] byte_count;

  typedef struct packed {
    logic [7:0] rxb;
    logic       first;
    logic [7:0] cmd;
    logic [5:0] cnt;
    logic       tog;
  } obs_t;

  obs_t       exp_q[$];
  logic [7:0] miso_q[$];
  int         n_checks, n_fail;

  logic [7:0] m_rx, m_cmd, m_tx;
  logic       m_first, m_tog, m_new;
  logic [5:0] m_cnt;

  spi_slave_frontend #(.DATA_W(8), .COUNT_W(6), .IDLE_TX(IDLE)) dut (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_byte(tx_byte), .rx_byte(rx_byte), .rx_toggle(rx_toggle), .rx_first(rx_first),
    .cmd_byte(cmd_byte), .byte_count(byte_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic obs_t dut_obs();
    return '{rxb: rx_byte, first: rx_first, cmd: cmd_byte, cnt: byte_count, tog: rx_toggle};
  endfunction

  function automatic obs_t model_obs();
    return '{rxb: m_rx, first: m_first, cmd: m_cmd, cnt: m_cnt, tog: m_tog};
  endfunction

  task automatic model_reset();
    m_rx = '0; m_cmd = '0; m_first = 1'b0; m_tog = 1'b0; m_cnt = '0;
    m_new = 1'b1; m_tx = IDLE;
  endtask

  // Expected outcome of one completed byte; txb is the reply queued for the next byte.
  task automatic model_byte(input logic [7:0] b, input logic [7:0] txb);
    m_rx    = b;
    m_first = m_new;
    if (m_new) begin
      m_cmd = b;
      m_cnt = 6'd1;
    end else if (m_cnt != 6'h3F) begin
      m_cnt = m_cnt + 6'd1;
    end
    m_new = 1'b0;
    m_tog = ~m_tog;
    exp_q.push_back(model_obs());
    miso_q.push_back(m_tx);
    m_tx = txb;
  endtask

  task automatic cs_low();
    @(posedge sclk); #1;
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    cs_n  = 1'b1;
    m_new = 1'b1;
    m_tx  = IDLE;
  endtask

  // Drives one byte starting just after a posedge; returns just after the 8th posedge.
  task automatic xfer_byte(input logic [7:0] b, input logic [7:0] txb,
                           output obs_t got, output logic [7:0] got_miso);
    model_byte(b, txb);
    for (int i = 7; i >= 0; i--) begin
      @(negedge sclk); #1;
      mosi = b[i];
      if (i == 0) tx_byte = txb;
      @(posedge sclk); #1;
      got_miso[i] = miso;
    end
    got = dut_obs();
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge sclk);
    #1;
    n_checks += 2;
    if (dut_obs() !== zero) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_obs(), zero);
    end
    if (miso !== IDLE[7]) begin
      n_fail++; $display("FAIL reset_miso: got %b expected %b", miso, IDLE[7]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    obs_t got, e; logic [7:0] gm, em;
    cs_low();
    xfer_byte(8'h10, 8'h00, got, gm);
    cs_high();
    e = exp_q.pop_front(); em = miso_q.pop_front();
    n_checks += 2;
    if (got !== e) begin n_fail++; $display("FAIL single_rx: got %h expected %h", got, e); end
    if (gm !== em) begin n_fail++; $display("FAIL single_miso: got %h expected %h", gm, em); end
  endtask

  task automatic test_multi();
    obs_t got, e; logic [7:0] gm, em;
    logic [7:0] b [3];
    b = '{8'h10, 8'h01, 8'h00};
    cs_low();
    for (int i = 0; i < 3; i++) begin
      xfer_byte(b[i], 8'h3C, got, gm);
      e = exp_q.pop_front(); em = miso_q.pop_front();
      n_checks += 2;
      if (got !== e) begin n_fail++; $display("FAIL multi_rx[%0d]: got %h expected %h", i, got, e); end
      if (gm !== em) begin n_fail++; $display("FAIL multi_miso[%0d]: got %h expected %h", i, gm, em); end
    end
    cs_high();
  endtask

  task automatic test_no_sclk();
    @(negedge sclk); #1;
    cs_n = 1'b0;
    #2;
    cs_n = 1'b1;
    #1;
    n_checks += 2;
    if (dut_obs() !== model_obs()) begin
      n_fail++; $display("FAIL no_sclk_hold: got %h expected %h", dut_obs(), model_obs());
    end
    if (miso !== IDLE[7]) begin
      n_fail++; $display("FAIL no_sclk_miso: got %b expected %b", miso, IDLE[7]);
    end
  endtask

  task automatic test_abort();
    obs_t got, e; logic [7:0] gm, em;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk); #1; mosi = 1'b1;
      @(posedge sclk); #1;
    end
    cs_high();
    repeat (3) @(posedge sclk);
    #1;
    n_checks++;
    if (dut_obs() !== model_obs()) begin
      n_fail++; $display("FAIL abort_hold: got %h expected %h", dut_obs(), model_obs());
    end
    cs_low();
    xfer_byte(8'h22, 8'h00, got, gm);
    cs_high();
    e = exp_q.pop_front(); em = miso_q.pop_front();
    n_checks += 2;
    if (got !== e) begin n_fail++; $display("FAIL abort_next_rx: got %h expected %h", got, e); end
    if (gm !== em) begin n_fail++; $display("FAIL abort_next_miso: got %h expected %h", gm, em); end
  endtask

  task automatic test_saturate();
    obs_t got, e; logic [7:0] gm, em;
    cs_low();
    for (int i = 0; i < 70; i++) begin
      xfer_byte(8'(i * 3 + 1), 8'(i ^ 8'h5A), got, gm);
      e = exp_q.pop_front(); em = miso_q.pop_front();
      n_checks += 2;
      if (got !== e) begin n_fail++; $display("FAIL sat_rx[%0d]: got %h expected %h", i, got, e); end
      if (gm !== em) begin n_fail++; $display("FAIL sat_miso[%0d]: got %h expected %h", i, gm, em); end
    end
    cs_high();
    n_checks++;
    if (byte_count !== 6'd63) begin
      n_fail++; $display("FAIL sat_final_count: got %0d expected 63", byte_count);
    end
  endtask

  task automatic test_rst_mid();
    obs_t got, e, zero; logic [7:0] gm, em;
    zero = '0;
    cs_low();
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk); #1; mosi = 1'b1;
      @(posedge sclk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (dut_obs() !== zero) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected %h", dut_obs(), zero);
    end
    if (miso !== IDLE[7]) begin
      n_fail++; $display("FAIL rst_mid_miso: got %b expected %b", miso, IDLE[7]);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    xfer_byte(8'h5A, 8'h00, got, gm);
    cs_high();
    e = exp_q.pop_front(); em = miso_q.pop_front();
    n_checks += 2;
    if (got !== e) begin n_fail++; $display("FAIL rst_mid_next_rx: got %h expected %h", got, e); end
    if (gm !== em) begin n_fail++; $display("FAIL rst_mid_next_miso: got %h expected %h", gm, em); end
  endtask

  task automatic test_back_to_back();
    obs_t got, e; logic [7:0] gm, em, b;
    cs_low();
    xfer_byte(8'h10, 8'h00, got, gm);
    cs_high();
    e = exp_q.pop_front(); em = miso_q.pop_front();
    n_checks += 2;
    if (got !== e) begin n_fail++; $display("FAIL b2b_first_rx: got %h expected %h", got, e); end
    if (gm !== em) begin n_fail++; $display("FAIL b2b_first_miso: got %h expected %h", gm, em); end
    for (int i = 0; i < 4; i++) begin
      @(posedge sclk); #1;
      n_checks++;
      if (cmd_byte !== 8'h10) begin
        n_fail++; $display("FAIL b2b_gap_cmd[%0d]: got %h expected 10", i, cmd_byte);
      end
    end
    cs_low();
    b = 8'h20;
    model_byte(b, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      @(negedge sclk); #1;
      mosi = b[i];
      @(posedge sclk); #1;
      gm[i] = miso;
      if (i > 0) begin
        n_checks++;
        if (cmd_byte !== 8'h10) begin
          n_fail++; $display("FAIL b2b_mid_cmd[bit %0d]: got %h expected 10", i, cmd_byte);
        end
      end
    end
    got = dut_obs();
    cs_high();
    e = exp_q.pop_front(); em = miso_q.pop_front();
    n_checks += 2;
    if (got !== e) begin n_fail++; $display("FAIL b2b_second_rx: got %h expected %h", got, e); end
    if (gm !== em) begin n_fail++; $display("FAIL b2b_second_miso: got %h expected %h", gm, em); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_multi();
    test_no_sclk();
    test_abort();
    test_saturate();
    test_rst_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
